// File: rtl/bin_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Purpose:
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It processes one operand bit per clock. The packed BCD digits feed the
//   seven-segment drivers. Operands larger than 10^DIGITS-1 raise err and
//   force every output nibble to 4'hF, which drives the drivers' E inputs.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When the macro is defined, blank[i] (i >= 1) is set at FINISH if digit i
//   and every higher digit are zero. blank[0] is never set, and blank is
//   cleared on err. These flags feed the drivers' OFF inputs.
//   When the macro is undefined, blank is tied low and has no registers.
//
// Parameters:
//   BIN_W   width of the binary operand (1..16)
//   DIGITS  number of BCD output digits (1..5)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active high
//   start    conversion request, honoured only in IDLE
//   bin_in   binary operand, captured on an accepted start
//   busy     high from the accepting edge until the FINISH edge
//   done     one-cycle pulse; bcd_out/err/blank valid until the next FINISH
//   bcd_out  packed BCD result, digit 0 (ones) in bits [3:0]
//   err      operand exceeded MAX_VAL
//   blank    leading-zero blank flags, one per digit
// ---------------------------------------------------------------------------
module bin_to_bcd_converter #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  err,
  output logic [DIGITS-1:0]     blank
);

  localparam int OUT_W = 4 * DIGITS;
  // One extra guard nibble absorbs the carry of operands up to 2^BIN_W-1,
  // so the add-3 step never wraps into garbage inside the visible digits.
  localparam int SCR_W = OUT_W + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic               over_max;
  logic               guard_msb_unused;

  // The range check is made on the raw operand. The guard nibble is not a
  // reliable overflow indicator, because digits 0..DIGITS-1 can overflow
  // without reaching the guard.
  assign over_max = ({{(32 - BIN_W){1'b0}}, bin_in} > MAX_VAL);

  // Add-3 correction: every nibble >= 5 gets +3 (4-bit modulo) in parallel,
  // so that the following left shift carries correctly into the next decade.
  for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_add3
    assign scratch_adj[gi*4 +: 4] = (scratch[gi*4 +: 4] >= 4'd5)
                                  ? scratch[gi*4 +: 4] + 4'd3
                                  : scratch[gi*4 +: 4];
  end

  // The top bit of the adjusted guard nibble is shifted out and discarded.
  assign guard_msb_unused = scratch_adj[SCR_W-1];

  // Control FSM and datapath, with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            cnt     <= CNT_W'(BIN_W);
            err_q   <= over_max;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          // {scratch, shreg} shifts left by one bit. The operand MSB enters
          // the scratch LSB after the add-3 correction.
          scratch <= {scratch_adj[SCR_W-2:0], shreg[BIN_W-1]};
          shreg   <= shreg << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          bcd_out <= err_q ? {OUT_W{1'b1}} : scratch[OUT_W-1:0];
          err     <= err_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_calc;
  logic [DIGITS-1:0] blank_reg;

  // Digit i blanks when the value sits entirely below decade i, that is,
  // when every digit from i upward is zero. The ones digit never blanks.
  assign blank_calc[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
    assign blank_calc[gi] = (scratch[OUT_W-1:4*gi] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_reg <= '0;
    end else if (state == FINISH) begin
      blank_reg <= err_q ? '0 : blank_calc;
    end
  end

  assign blank = blank_reg;
`else
  assign blank = '0;
`endif

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one bit per clock. It is the reverse path of the existing BCD-to-binary/octal datapath: a switch-entered binary value is converted to packed BCD digits for the existing seven-segment drivers. Values that do not fit in DIGITS decimal digits raise an error flag. The error flag drives the drivers' E inputs, matching the invalid-digit display path.

Parameters:
BIN_W, 10, width of the binary input (1..16)
DIGITS, 3, number of BCD output digits (1..5); MAX_VAL = 10^DIGITS - 1 is a derived localparam

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  conversion request, sampled only in IDLE
bin_in  input  BIN_W  binary operand, captured on accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd_out/err valid from this cycle until the next accepted start
bcd_out  output  4*DIGITS  packed BCD result; digit0 (ones) in bits [3:0]
err  output  1  operand > MAX_VAL
blank  output  DIGITS  leading-zero blank flags per digit (see Optional Feature)

Behaviour:
- Reset: state=IDLE, busy=0, done=0, err=0, bcd_out=0, blank=0; internal shift/scratch registers and counter cleared. Reset overrides start, including reset mid-conversion; the aborted result is never presented and done does not pulse.
- States: IDLE, SHIFT, FINISH.
- IDLE: done=0 except in the single cycle after FINISH. start=1 at edge k:
  - capture bin_in into the shift register;
  - clear BCD scratch (4*DIGITS+4 bits, one guard nibble);
  - cnt=BIN_W;
  - err_q = (bin_in > MAX_VAL);
  - busy=1;
  - go to SHIFT.
- SHIFT: one iteration per edge.
  - Every scratch nibble >= 5 gets +3, all nibbles in parallel.
  - Then {scratch, shreg} shifts left one bit; shreg MSB enters scratch bit 0.
  - cnt decrements. When cnt==1 at the edge, go to FINISH.
- FINISH (one edge):
  - bcd_out = err_q ? all nibbles 4'hF : scratch[4*DIGITS-1:0];
  - err = err_q;
  - blank updated;
  - done=1 for exactly one cycle;
  - busy=0;
  - go to IDLE.
- Latency: start sampled at edge k gives done high in the cycle following edge k+BIN_W+1 (11 cycles at BIN_W=10). Throughput is one conversion per BIN_W+2 cycles. start held high restarts immediately.
- start while busy=1 is ignored; bin_in changes during a conversion have no effect.
- start high in the done cycle (state already IDLE) is accepted. done and the new busy both appear on that edge. bcd_out/err hold the previous result until the next FINISH.
- Arithmetic: add-3 is 4-bit modulo. The guard nibble absorbs the carry for operands up to 2^BIN_W-1 but is never output. err is decided solely by the comparator, not by the guard nibble.
- bin_in = 0 produces bcd_out = 0, err=0.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: at FINISH, blank[i]=1 for i>=1 when digit i and all higher digits are 0. blank[0] is always 0. blank is all 0 when err=1. Connects to the drivers' OFF inputs.
- Undefined: blank is tied to 0 constantly; no extra registers.

Test Plan:
- Reset, then start with bin_in=0 -> done exactly 11 cycles later, bcd_out=12'h000, err=0, blank=3'b110 (with macro) / 3'b000 (without).
- bin_in=10'd999 -> bcd_out=12'h999, err=0, blank=3'b000; bin_in=10'd255 -> bcd_out=12'h255.
- bin_in=10'd1000 and 10'd1023 -> err=1, bcd_out=12'hFFF, blank=0.
- Start bin_in=10'd37, pulse start again at cycle +4 with bin_in=10'd512 -> only one done, result 12'h037 (blank=3'b100 with macro); busy stays high throughout.
- Assert rst at cycle +5 of a conversion of 10'd800 -> next cycle busy=0, bcd_out=0, done never pulses; a new start of 10'd800 yields 12'h800.
- Back-to-back: start=1 held continuously with bin_in 10'd1, then 10'd42 -> done pulses every 12 cycles, results 12'h001 then 12'h042; previous result stable between done pulses.
